anchor_scheduler: RTL and testbench

- Frame-level sequencer for the edge-detector filter pipeline (blur, sobel, nms stages).
- Steps the processing anchor across the image in raster order and requests a window load for each anchor position.
- Pulses anchor_moving to launch each stage controller, then waits until every stage reports its final flag before advancing.
- Reports frame completion and a window count.

---
 rtl/anchor_scheduler.sv | 162 ++++++++++++++++
 tb/tb_anchor_scheduler.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/anchor_scheduler.sv
// Frame-level sequencer for the blur/sobel/nms pipeline: walks the processing
// anchor in raster order, launches the stage controllers and joins their final flags.
module anchor_scheduler #(
    parameter int unsigned IMG_W         = 640,
    parameter int unsigned IMG_H         = 480,
    parameter int unsigned STEP_X        = 12,
    parameter int unsigned STEP_Y        = 1,
    parameter int unsigned NUM_STAGES    = 3,
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  n_rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  pause,
    input  logic                  mem_ready,
    input  logic [NUM_STAGES-1:0] stage_final,
    output logic                  load_req,
    output logic                  anchor_moving,
    output logic [31:0]           anchor_x,
    output logic [31:0]           anchor_y,
    output logic                  busy,
    output logic                  frame_done,
    output logic [15:0]           win_count
);

    // Last legal anchor positions: the largest stride multiple that still fits.
    localparam logic [31:0] MAX_X       = 32'((IMG_W - STEP_X) / STEP_X * STEP_X);
    localparam logic [31:0] MAX_Y       = 32'((IMG_H - STEP_Y) / STEP_Y * STEP_Y);
    localparam logic [31:0] STEP_X_W    = 32'(STEP_X);
    localparam logic [31:0] STEP_Y_W    = 32'(STEP_Y);
    localparam logic [3:0]  SETTLE_INIT = 4'(SETTLE_CYCLES);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        MOVE,
        SETTLE,
        WAIT,
        ADVANCE,
        HOLD,
        DONE
    } state_e;

    state_e      state_q,    state_d;
    logic [31:0] anchor_x_q, anchor_x_d;
    logic [31:0] anchor_y_q, anchor_y_d;
    logic [15:0] win_cnt_q,  win_cnt_d;
    logic [3:0]  settle_q,   settle_d;

    logic load_req_q,      load_req_d;
    logic anchor_moving_q, anchor_moving_d;
    logic busy_q,          busy_d;
    logic frame_done_q,    frame_done_d;

    always_comb begin
        // NOTE: every signal assigned below gets its hold value first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_d    = state_q;
        anchor_x_d = anchor_x_q;
        anchor_y_d = anchor_y_q;
        win_cnt_d  = win_cnt_q;
        settle_d   = settle_q;

        unique case (state_q)
            IDLE: begin
                if (start && !abort) begin
                    anchor_x_d = '0;
                    anchor_y_d = '0;
                    win_cnt_d  = '0;
                    state_d    = LOAD;
                end
            end
            LOAD: begin
                if (mem_ready) state_d = MOVE;
            end
            MOVE: begin
                settle_d = SETTLE_INIT;
                state_d  = SETTLE;
            end
            SETTLE: begin
                // Stage flags may still be stale from the previous window here.
                settle_d = settle_q - 4'd1;
                if (settle_q <= 4'd1) state_d = WAIT;
            end
            WAIT: begin
                if (&stage_final) state_d = ADVANCE;
            end
            ADVANCE: begin
                if (win_cnt_q != 16'hFFFF) win_cnt_d = win_cnt_q + 16'd1;
                if (anchor_x_q == MAX_X && anchor_y_q == MAX_Y) begin
                    state_d = DONE;
                end else begin
                    if (anchor_x_q == MAX_X) begin
                        anchor_x_d = '0;
                        anchor_y_d = anchor_y_q + STEP_Y_W;
                    end else begin
                        anchor_x_d = anchor_x_q + STEP_X_W;
                    end
                    state_d = pause ? HOLD : LOAD;
                end
            end
            HOLD: begin
                if (!pause) state_d = LOAD;
            end
            DONE: begin
                anchor_x_d = '0;
                anchor_y_d = '0;
                state_d    = IDLE;
            end
        endcase

        // Abort overrides every transition above; the window count is kept.
        if (abort && state_q != IDLE) begin
            state_d    = IDLE;
            anchor_x_d = '0;
            anchor_y_d = '0;
        end

        // Outputs are registered from the next state, so they match a Moore decode
        // of the current state without any combinational path to the ports.
        load_req_d      = (state_d == LOAD);
        anchor_moving_d = (state_d == MOVE);
        frame_done_d    = (state_d == DONE);
        busy_d          = (state_d != IDLE);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q         <= IDLE;
            anchor_x_q      <= '0;
            anchor_y_q      <= '0;
            win_cnt_q       <= '0;
            settle_q        <= '0;
            load_req_q      <= 1'b0;
            anchor_moving_q <= 1'b0;
            busy_q          <= 1'b0;
            frame_done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the _d values
            // of the same cycle, independent of statement order.
            state_q         <= state_d;
            anchor_x_q      <= anchor_x_d;
            anchor_y_q      <= anchor_y_d;
            win_cnt_q       <= win_cnt_d;
            settle_q        <= settle_d;
            load_req_q      <= load_req_d;
            anchor_moving_q <= anchor_moving_d;
            busy_q          <= busy_d;
            frame_done_q    <= frame_done_d;
        end
    end

    assign load_req      = load_req_q;
    assign anchor_moving = anchor_moving_q;
    assign anchor_x      = anchor_x_q;
    assign anchor_y      = anchor_y_q;
    assign busy          = busy_q;
    assign frame_done    = frame_done_q;
    assign win_count     = win_cnt_q;

endmodule

// File: tb/tb_anchor_scheduler.sv
// Directed bench for anchor_scheduler on a 36x3 image: expected anchors are queued
// ahead of each frame and compared whenever the DUT pulses anchor_moving.
module tb_anchor_scheduler;

    localparam int unsigned SETTLE = 2;

    logic        clk;
    logic        n_rst;
    logic        start;
    logic        abort;
    logic        pause;
    logic        mem_ready;
    logic [2:0]  stage_final;
    logic        load_req;
    logic        anchor_moving;
    logic [31:0] anchor_x;
    logic [31:0] anchor_y;
    logic        busy;
    logic        frame_done;
    logic [15:0] win_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [63:0] exp_q[$];
    logic [63:0] mon_exp;
    int          move_cnt  = 0;
    int          load_eps  = 0;
    int          done_cnt  = 0;
    logic        load_prev = 1'b0;

    anchor_scheduler #(
        .IMG_W        (36),
        .IMG_H        (3),
        .STEP_X       (12),
        .STEP_Y       (1),
        .NUM_STAGES   (3),
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .start        (start),
        .abort        (abort),
        .pause        (pause),
        .mem_ready    (mem_ready),
        .stage_final  (stage_final),
        .load_req     (load_req),
        .anchor_moving(anchor_moving),
        .anchor_x     (anchor_x),
        .anchor_y     (anchor_y),
        .busy         (busy),
        .frame_done   (frame_done),
        .win_count    (win_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_anchor(input int x, input int y);
        exp_q.push_back({32'(x), 32'(y)});
    endtask

    // Returns at the falling edge of the next anchor_moving pulse.
    task automatic wait_move(input string tag);
        logic found = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (anchor_moving) begin
                found = 1'b1;
                break;
            end
        end
        check({tag, "_seen"}, found, 1'b1);
    endtask

    // Scoreboard side: every launch pulse consumes one expected anchor.
    always @(negedge clk) begin
        if (n_rst) begin
            if (anchor_moving) begin
                move_cnt++;
                check("move_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    mon_exp = exp_q.pop_front();
                    check("move_anchor", {anchor_x, anchor_y}, mon_exp);
                end
            end
            if (load_req && !load_prev) load_eps++;
            if (frame_done) done_cnt++;
        end
        load_prev = load_req;
    end

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] sf_hold;
        logic       found;
        logic       ok;
        int         m1, m2, m3, t12;

        n_rst       = 1'b0;
        start       = 1'b0;
        abort       = 1'b0;
        pause       = 1'b0;
        mem_ready   = 1'b0;
        stage_final = 3'b000;
        repeat (3) @(negedge clk);
        check("reset_outputs",
              {load_req, anchor_moving, busy, frame_done, anchor_x, anchor_y, win_count},
              {1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 16'd0});
        n_rst = 1'b1;
        @(negedge clk);

        // Full frame: finals low while settling, then high.
        for (int y = 0; y < 3; y++)
            for (int x = 0; x < 36; x += 12) push_anchor(x, y);
        mem_ready = 1'b1;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_state", {busy, load_req, win_count}, {1'b1, 1'b1, 16'd0});
        sf_hold = '0;
        found   = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (frame_done) begin
                found = 1'b1;
                break;
            end
            if (anchor_moving) sf_hold = 3'(SETTLE);
            if (sf_hold != 0) begin
                stage_final = 3'b000;
                sf_hold--;
            end else begin
                stage_final = 3'b111;
            end
            @(negedge clk);
        end
        check("frame_done_seen", found, 1'b1);
        check("done_cycle", {busy, anchor_x, anchor_y}, {1'b1, 32'd24, 32'd2});
        @(negedge clk);
        check("after_done",
              {busy, frame_done, anchor_x, anchor_y, win_count},
              {1'b0, 1'b0, 32'd0, 32'd0, 16'd9});
        check("frame_moves", move_cnt, 9);
        check("frame_loads", load_eps, 9);
        check("frame_dones", done_cnt, 1);
        check("frame_queue_empty", exp_q.size(), 0);

        // Settle masking: finals already high must not shorten the window.
        stage_final = 3'b111;
        push_anchor(0, 0);
        push_anchor(12, 0);
        push_anchor(24, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_move("mask_w1");
        m1  = cyc;
        t12 = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (anchor_x == 32'd12) begin
                t12 = cyc;
                break;
            end
        end
        check("move_to_advance", t12 - m1, SETTLE + 3);
        wait_move("mask_w2");
        m2 = cyc;
        check("window_period_1", m2 - m1, 4 + SETTLE);
        wait_move("mask_w3");
        m3 = cyc;
        check("window_period_2", m3 - m2, 4 + SETTLE);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_in_move",
              {busy, load_req, anchor_moving, frame_done, anchor_x, anchor_y, win_count},
              {1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 16'd2});

        // Partial finals: 3'b011 must never advance the anchor.
        stage_final = 3'b011;
        push_anchor(0, 0);
        push_anchor(12, 0);
        push_anchor(24, 0);
        push_anchor(0, 1);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("restart_clears",
              {busy, load_req, anchor_x, anchor_y, win_count},
              {1'b1, 1'b1, 32'd0, 32'd0, 16'd0});
        wait_move("partial_w1");
        ok = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ok &= (anchor_x == 32'd0) && !load_req && !anchor_moving && busy;
        end
        check("partial_stalls", ok, 1'b1);
        stage_final = 3'b111;
        @(negedge clk);
        check("advance_cycle", {anchor_x, load_req}, {32'd0, 1'b0});
        @(negedge clk);
        check("advanced_x", {anchor_x, load_req, win_count}, {32'd12, 1'b1, 16'd1});

        // Pause raised during window 2's WAIT, released 10 cycles after ADVANCE.
        stage_final = 3'b000;
        wait_move("pause_w2");
        repeat (3) @(negedge clk);
        pause       = 1'b1;
        stage_final = 3'b111;
        @(negedge clk);
        ok = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            ok &= (anchor_x == 32'd24) && !load_req && busy;
        end
        pause = 1'b0;
        check("hold_frozen", ok, 1'b1);
        @(negedge clk);
        check("hold_release", {load_req, anchor_x, win_count}, {1'b1, 32'd24, 16'd2});

        // Abort (with start) while window 5 waits for memory.
        wait_move("abort_w3");
        wait_move("abort_w4");
        mem_ready = 1'b0;
        found     = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (load_req) begin
                found = 1'b1;
                break;
            end
        end
        check("w5_load_seen", found, 1'b1);
        check("w5_anchor", {anchor_x, anchor_y, win_count}, {32'd12, 32'd1, 16'd4});
        ok = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ok &= load_req && !anchor_moving;
        end
        check("load_waits_for_mem", ok, 1'b1);
        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        check("abort_in_load",
              {busy, load_req, anchor_moving, frame_done, anchor_x, anchor_y, win_count},
              {1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 16'd4});
        @(negedge clk);
        check("abort_no_restart", {busy, done_cnt}, {1'b0, 32'd1});

        abort = 1'b1;
        start = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        check("idle_abort_wins", {busy, load_req, win_count}, {1'b0, 1'b0, 16'd4});

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("late_start",
              {busy, load_req, anchor_x, anchor_y, win_count},
              {1'b1, 1'b1, 32'd0, 32'd0, 16'd0});
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("late_abort", busy, 1'b0);

        // Asynchronous reset while stalled in window 2's WAIT.
        mem_ready   = 1'b1;
        stage_final = 3'b111;
        push_anchor(0, 0);
        push_anchor(12, 0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_move("rst_w1");
        wait_move("rst_w2");
        stage_final = 3'b000;
        repeat (5) @(negedge clk);
        check("pre_reset", {busy, anchor_x, win_count}, {1'b1, 32'd12, 16'd1});
        #1 n_rst = 1'b0;
        @(negedge clk);
        check("reset_mid_wait",
              {load_req, anchor_moving, busy, frame_done, anchor_x, anchor_y, win_count},
              {1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 16'd0});
        n_rst = 1'b1;
        @(negedge clk);
        check("post_reset_idle", {busy, load_req}, {1'b0, 1'b0});
        check("total_moves", move_cnt, 18);
        check("final_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
